// File: rtl/ip_rx_dest_filter.sv
// ip_rx_dest_filter: classifies received IP headers by destination and forwards or discards each packet.
// Define IP_RX_FILTER_MULTICAST_EN to accept multicast destinations with class 11.
module ip_rx_dest_filter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_ip_hdr_valid,
  output logic                   s_ip_hdr_ready,
  input  logic [31:0]            s_ip_dest_ip,
  input  logic [7:0]             s_ip_payload_axis_tdata,
  input  logic                   s_ip_payload_axis_tvalid,
  output logic                   s_ip_payload_axis_tready,
  input  logic                   s_ip_payload_axis_tlast,
  input  logic                   s_ip_payload_axis_tuser,
  output logic                   m_ip_hdr_valid,
  input  logic                   m_ip_hdr_ready,
  output logic [31:0]            m_ip_dest_ip,
  output logic [1:0]             m_ip_dest_class,
  output logic [7:0]             m_ip_payload_axis_tdata,
  output logic                   m_ip_payload_axis_tvalid,
  input  logic                   m_ip_payload_axis_tready,
  output logic                   m_ip_payload_axis_tlast,
  output logic                   m_ip_payload_axis_tuser,
  input  logic [31:0]            local_ip,
  input  logic [31:0]            subnet_mask,
  input  logic                   counter_clear,
  output logic [COUNT_WIDTH-1:0] accept_count,
  output logic [COUNT_WIDTH-1:0] drop_count
);
  typedef enum logic [2:0] {IDLE, CLASSIFY, HDR_OUT, PASS, DROP} state_t;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;
  state_t state, state_next;
  logic [31:0] dest_r, local_r, mask_r;
  logic [1:0] class_r, cls;
  logic lim, sub, uni, accept, hdr_xfer, s_xfer, drop_inc;
  always_comb begin
    lim = dest_r == ONES;
    sub = !lim && mask_r != ONES && (dest_r & mask_r) == (local_r & mask_r) && (dest_r | mask_r) == ONES;
    uni = dest_r == local_r && local_r != '0;
`ifdef IP_RX_FILTER_MULTICAST_EN
    accept = lim || sub || uni || dest_r[31:28] == 4'hE;
    cls = lim ? 2'b10 : sub ? 2'b01 : uni ? 2'b00 : 2'b11;
`else
    accept = lim || sub || uni;
    cls = lim ? 2'b10 : sub ? 2'b01 : 2'b00;
`endif
  end
  assign hdr_xfer = state == HDR_OUT && m_ip_hdr_ready;
  assign s_xfer = s_ip_payload_axis_tvalid && s_ip_payload_axis_tready;
  assign drop_inc = state == CLASSIFY && !accept;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_next;
  end
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     state_next = s_ip_hdr_valid ? CLASSIFY : IDLE;
      CLASSIFY: state_next = accept ? HDR_OUT : DROP;
      HDR_OUT:  state_next = m_ip_hdr_ready ? PASS : HDR_OUT;
      PASS:     state_next = s_xfer && s_ip_payload_axis_tlast ? IDLE : PASS;
      DROP:     state_next = s_xfer && s_ip_payload_axis_tlast ? IDLE : DROP;
      default:  state_next = IDLE;
    endcase
  end
  // Header ready is gated by reset so no handshake can be seen while held in reset.
  always_comb begin
    s_ip_hdr_ready = rst && state == IDLE;
    m_ip_hdr_valid = state == HDR_OUT;
    s_ip_payload_axis_tready = state == PASS ? m_ip_payload_axis_tready : state == DROP;
    m_ip_payload_axis_tvalid = state == PASS && s_ip_payload_axis_tvalid;
    m_ip_payload_axis_tdata = s_ip_payload_axis_tdata;
    m_ip_payload_axis_tlast = s_ip_payload_axis_tlast;
    m_ip_payload_axis_tuser = s_ip_payload_axis_tuser;
  end
  assign m_ip_dest_ip = dest_r;
  assign m_ip_dest_class = class_r;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dest_r <= '0;
      local_r <= '0;
      mask_r <= '0;
      class_r <= '0;
    end else begin
      if (state == IDLE && s_ip_hdr_valid) begin
        dest_r <= s_ip_dest_ip;
        local_r <= local_ip;
        mask_r <= subnet_mask;
      end
      if (state == CLASSIFY) class_r <= cls;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      accept_count <= '0;
      drop_count <= '0;
    end else if (counter_clear) begin
      accept_count <= '0;
      drop_count <= '0;
    end else begin
      if (hdr_xfer && accept_count != '1) accept_count <= accept_count + COUNT_WIDTH'(1);
      if (drop_inc && drop_count != '1) drop_count <= drop_count + COUNT_WIDTH'(1);
    end
  end
endmodule
